// File: rtl/sifh_pingpong_peak_histogrammer.sv
// Ping-pong coarse histogrammer: one bank fills with TDC timestamps while the other
// is scanned (read-and-clear) for its peak bin, one peak report per pixel.
module sifh_pingpong_peak_histogrammer #(
  parameter  int NP        = 10,
  parameter  int BIN_SHIFT = 5,
  parameter  int PIXEL_NUM = 3,
  parameter  int SAMPLES   = 8,
  parameter  int CNT_W     = 8,
  parameter  int SKIP_ZERO = 1,
  localparam int BW        = NP - BIN_SHIFT,
  localparam int NBIN      = 2 ** BW,
  localparam int PW        = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1,
  localparam int SW        = $clog2(SAMPLES) + 1
) (
  input  logic                    i_clk,
  input  logic                    i_res,
  input  logic                    i_wrEn,
  input  logic [NP-1:0]           i_data,
  output logic                    o_in_ready,
  output logic                    o_peak_valid,
  output logic [PW-1:0]           o_peak_pix,
  output logic [BW-1:0]           o_peak_bin,
  output logic [CNT_W-1:0]        o_peak_cnt,
  output logic [PIXEL_NUM*BW-1:0] o_peakResult,
  output logic                    o_frame_done,
  output logic                    o_sat_flag
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t           r_state, w_nextState;
  logic [CNT_W-1:0] r_bank [2][NBIN];
  logic             r_fill;
  logic [PW-1:0]    r_pix;
  logic [SW-1:0]    r_sampCnt;
  logic [1:0]       r_pending;
  logic [PW-1:0]    r_tag [2];
  logic             r_scanBank;
  logic [BW-1:0]    r_scanIdx, r_bestBin;
  logic [CNT_W-1:0] r_bestCnt;

  logic             w_fillFree, w_accept, w_close, w_binned, w_atMax;
  logic             w_canStart, w_startBank, w_start, w_step, w_report;
  logic [BW-1:0]    w_bin;
  logic [CNT_W-1:0] w_cur, w_scanCnt;
  logic [PW-1:0]    w_reportPix;

  assign w_fillFree  = !r_pending[r_fill] && !(r_state == S_SCAN && r_scanBank == r_fill);
  assign o_in_ready  = i_res && w_fillFree;
  assign w_accept    = i_wrEn && o_in_ready;
  assign w_close     = w_accept && (r_sampCnt == SW'(SAMPLES - 1));
  assign w_bin       = i_data[NP-1:BIN_SHIFT];
  assign w_binned    = w_accept && !((SKIP_ZERO != 0) && (i_data == '0));
  assign w_cur       = r_bank[r_fill][w_bin];
  assign w_atMax     = &w_cur;
  assign w_scanCnt   = r_bank[r_scanBank][r_scanIdx];
  assign w_reportPix = r_tag[r_scanBank];

  // A bank already waiting is always older than one closing this very cycle.
  assign w_canStart  = (r_state != S_SCAN) && ((|r_pending) || w_close);
  assign w_startBank = r_pending[0] ? 1'b0 : (r_pending[1] ? 1'b1 : r_fill);

  always_ff @(posedge i_clk) begin
    if (!i_res) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (w_canStart) w_nextState = S_SCAN;
      S_SCAN:  if (r_scanIdx == BW'(NBIN - 1)) w_nextState = S_DONE;
      S_DONE:  w_nextState = w_canStart ? S_SCAN : S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    w_start  = 1'b0;
    w_step   = 1'b0;
    w_report = 1'b0;
    if (r_state != S_SCAN && w_nextState == S_SCAN) w_start = 1'b1;
    if (r_state == S_SCAN) w_step = 1'b1;
    if (r_state == S_DONE) w_report = 1'b1;
  end

  // Fill increments and scan clears always hit different banks.
  always_ff @(posedge i_clk) begin
    if (!i_res) begin
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < NBIN; k++)
          r_bank[b][k] <= '0;
      o_sat_flag <= 1'b0;
    end else begin
      if (w_binned && !w_atMax) r_bank[r_fill][w_bin] <= w_cur + 1'b1;
      if (w_binned && w_atMax)  o_sat_flag <= 1'b1;
      if (w_step)               r_bank[r_scanBank][r_scanIdx] <= '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_res) begin
      r_fill    <= 1'b0;
      r_pix     <= '0;
      r_sampCnt <= '0;
      r_pending <= '0;
      r_tag[0]  <= '0;
      r_tag[1]  <= '0;
    end else begin
      if (w_accept) begin
        if (w_close) begin
          r_sampCnt     <= '0;
          r_fill        <= ~r_fill;
          r_tag[r_fill] <= r_pix;
          r_pix         <= (r_pix == PW'(PIXEL_NUM - 1)) ? '0 : r_pix + 1'b1;
        end else begin
          r_sampCnt <= r_sampCnt + 1'b1;
        end
      end
      for (int b = 0; b < 2; b++)
        r_pending[b] <= (r_pending[b] || (w_close && r_fill == b))
                        && !(w_start && w_startBank == b);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_res) begin
      r_scanBank   <= 1'b0;
      r_scanIdx    <= '0;
      r_bestBin    <= '0;
      r_bestCnt    <= '0;
      o_peak_valid <= 1'b0;
      o_frame_done <= 1'b0;
      o_peak_pix   <= '0;
      o_peak_bin   <= '0;
      o_peak_cnt   <= '0;
      o_peakResult <= '0;
    end else begin
      o_peak_valid <= w_report;
      o_frame_done <= w_report && (w_reportPix == PW'(PIXEL_NUM - 1));
      if (w_report) begin
        o_peak_pix <= w_reportPix;
        o_peak_bin <= r_bestBin;
        o_peak_cnt <= r_bestCnt;
        o_peakResult[int'(w_reportPix)*BW +: BW] <= r_bestBin;
      end
      if (w_start) begin
        r_scanBank <= w_startBank;
        r_scanIdx  <= '0;
        r_bestBin  <= '0;
        r_bestCnt  <= '0;
      end else if (w_step) begin
        if (w_scanCnt > r_bestCnt) begin
          r_bestBin <= r_scanIdx;
          r_bestCnt <= w_scanCnt;
        end
        r_scanIdx <= r_scanIdx + 1'b1;
      end
    end
  end

endmodule
